// File: rtl/eth_ipv4_pkg.sv
// eth_ipv4_pkg: shared constants, IPv4 field offsets and parser state encoding
package eth_ipv4_pkg;
    localparam logic [15:0] ETHTYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETHTYPE_VLAN   = 16'h8100;
    localparam logic [15:0] ETH_HDR_BYTES  = 16'd14;
    localparam logic [15:0] VLAN_TAG_BYTES = 16'd4;
    localparam logic [15:0] IP_OFF_VER_IHL = 16'd0;
    localparam logic [15:0] IP_OFF_TOTLEN  = 16'd2;
    localparam logic [15:0] IP_OFF_PROTO   = 16'd9;
    localparam logic [15:0] IP_OFF_SRC     = 16'd12;
    localparam logic [15:0] IP_OFF_DST     = 16'd16;
    localparam logic [47:0] MAC_BCAST      = 48'hffff_ffff_ffff;
    typedef enum logic [2:0] {S_ETH, S_IP, S_PAYLOAD, S_TRAIL, S_META, S_DROP} parser_state_e;
endpackage

// File: rtl/ipv4_csum_acc.sv
// ipv4_csum_acc: byte-serial ones-complement accumulator for the IPv4 header checksum
// clear resets the sum; byte_valid/data feed header bytes, high byte of each word first.
// csum_ok is combinational and includes the byte currently presented, so it is meaningful
// while the final (low) header byte is on data.
module ipv4_csum_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] data,
    output logic       csum_ok
);
    logic [15:0] sum;
    logic [7:0]  hi;
    logic        odd;
    logic [16:0] raw;
    logic [15:0] folded;
    assign raw     = {1'b0, sum} + {1'b0, hi, data};
    assign folded  = raw[15:0] + {15'd0, raw[16]};
    assign csum_ok = folded == 16'hffff;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            hi  <= '0;
            odd <= 1'b0;
        end else if (clear) begin
            sum <= '0;
            hi  <= '0;
            odd <= 1'b0;
        end else if (byte_valid) begin
            if (odd) sum <= folded;
            else hi <= data;
            odd <= !odd;
        end
    end
endmodule

// File: rtl/ethernet_ipv4_parser.sv
// ethernet_ipv4_parser: Ethernet II / optional 802.1Q / IPv4 header parser with payload forwarding
// s_axis_*: frame bytes in (dst MAC first, FCS last); m_axis_*: IPv4 payload bytes out.
// meta_*: per-frame summary held until meta_ready; cfg_local_mac: station MAC for filtering.
// stat_rx_frames / stat_drop_frames: saturating accepted / dropped frame counters.
module ethernet_ipv4_parser
    import eth_ipv4_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VLAN_EN       = 1,
    parameter int CHECK_CSUM    = 1,
    parameter int MAC_FILTER_EN = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic [47:0]           meta_dst_mac,
    output logic [47:0]           meta_src_mac,
    output logic                  meta_vlan_present,
    output logic [11:0]           meta_vlan_id,
    output logic [31:0]           meta_src_ip,
    output logic [31:0]           meta_dst_ip,
    output logic [7:0]            meta_protocol,
    output logic [15:0]           meta_payload_len,
    output logic                  meta_truncated,
    input  logic [47:0]           cfg_local_mac,
    output logic [CNT_WIDTH-1:0]  stat_rx_frames,
    output logic [CNT_WIDTH-1:0]  stat_drop_frames
);
    parser_state_e state, state_n;
    logic        acc, last_ip, bad, mac_ok, drop_evt, csum_ok;
    logic [15:0] off, hdr_len, ip_idx, ip_len, ihl4, plen, rem, total_len, etype;
    logic [7:0]  prev, ver_ihl;
    assign s_axis_tready = state == S_META ? 1'b0 : state == S_PAYLOAD ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
    assign acc        = s_axis_tvalid && s_axis_tready;
    // meta waits until the final payload beat has left the output register
    assign meta_valid = state == S_META && !m_axis_tvalid;
    assign hdr_len    = meta_vlan_present ? ETH_HDR_BYTES + VLAN_TAG_BYTES : ETH_HDR_BYTES;
    assign ip_idx     = off - hdr_len;
    assign ihl4       = {10'd0, ver_ihl[3:0], 2'b00};
    // an illegal IHL still consumes a minimum header so the drop decision has a fixed point
    assign ip_len     = ver_ihl[3:0] < 4'd5 ? 16'd20 : ihl4;
    assign last_ip    = ip_idx == ip_len - 16'd1;
    assign plen       = total_len - ihl4;
    assign etype      = {prev, s_axis_tdata};
    assign mac_ok     = MAC_FILTER_EN == 0 || meta_dst_mac == cfg_local_mac || meta_dst_mac == MAC_BCAST;
    assign bad        = ver_ihl[7:4] != 4'd4 || ver_ihl[3:0] < 4'd5 || total_len < ihl4 ||
                        (CHECK_CSUM != 0 && !csum_ok) || !mac_ok;
    ipv4_csum_acc u_csum (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == S_ETH),
        .byte_valid (acc && state == S_IP),
        .data       (s_axis_tdata),
        .csum_ok    (csum_ok)
    );
    always_comb begin
        state_n  = state;
        drop_evt = 1'b0;
        case (state)
            S_ETH: if (acc) begin
                if (s_axis_tlast) drop_evt = 1'b1;
                else if (off == hdr_len - 16'd1) begin
                    if (etype == ETHTYPE_IPV4) state_n = S_IP;
                    else if (!(etype == ETHTYPE_VLAN && VLAN_EN != 0 && !meta_vlan_present)) begin
                        state_n  = S_DROP;
                        drop_evt = 1'b1;
                    end
                end
            end
            S_IP: if (acc) begin
                if (s_axis_tlast) begin
                    state_n  = S_ETH;
                    drop_evt = 1'b1;
                end else if (last_ip) begin
                    state_n  = bad ? S_DROP : plen == 16'd0 ? S_TRAIL : S_PAYLOAD;
                    drop_evt = bad;
                end
            end
            S_PAYLOAD: if (acc) state_n = s_axis_tlast ? S_META : rem == 16'd1 ? S_TRAIL : S_PAYLOAD;
            S_TRAIL:   if (acc && s_axis_tlast) state_n = S_META;
            S_META:    if (meta_valid && meta_ready) state_n = S_ETH;
            S_DROP:    if (acc && s_axis_tlast) state_n = S_ETH;
            default:   state_n = S_ETH;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_ETH;
            off               <= '0;
            prev              <= '0;
            ver_ihl           <= '0;
            total_len         <= '0;
            rem               <= '0;
            m_axis_tdata      <= '0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            meta_dst_mac      <= '0;
            meta_src_mac      <= '0;
            meta_vlan_present <= 1'b0;
            meta_vlan_id      <= '0;
            meta_src_ip       <= '0;
            meta_dst_ip       <= '0;
            meta_protocol     <= '0;
            meta_payload_len  <= '0;
            meta_truncated    <= 1'b0;
            stat_rx_frames    <= '0;
            stat_drop_frames  <= '0;
        end else begin
            state <= state_n;
            if (acc) begin
                off  <= s_axis_tlast ? 16'd0 : off + 16'd1;
                prev <= s_axis_tdata;
            end
            if (acc && state == S_ETH) begin
                if (off == 16'd0) begin
                    meta_vlan_present <= 1'b0;
                    meta_vlan_id      <= '0;
                    meta_truncated    <= 1'b0;
                end
                if (off < 16'd6) meta_dst_mac <= {meta_dst_mac[39:0], s_axis_tdata};
                else if (off < 16'd12) meta_src_mac <= {meta_src_mac[39:0], s_axis_tdata};
                if (off == 16'd13 && etype == ETHTYPE_VLAN && VLAN_EN != 0) meta_vlan_present <= 1'b1;
                if (off == 16'd15 && meta_vlan_present) meta_vlan_id <= {prev[3:0], s_axis_tdata};
            end
            if (acc && state == S_IP) begin
                if (ip_idx == IP_OFF_VER_IHL) ver_ihl <= s_axis_tdata;
                if (ip_idx == IP_OFF_TOTLEN || ip_idx == IP_OFF_TOTLEN + 16'd1) total_len <= {total_len[7:0], s_axis_tdata};
                if (ip_idx == IP_OFF_PROTO) meta_protocol <= s_axis_tdata;
                if (ip_idx >= IP_OFF_SRC && ip_idx < IP_OFF_DST) meta_src_ip <= {meta_src_ip[23:0], s_axis_tdata};
                if (ip_idx >= IP_OFF_DST && ip_idx < IP_OFF_DST + 16'd4) meta_dst_ip <= {meta_dst_ip[23:0], s_axis_tdata};
                if (last_ip) begin
                    meta_payload_len <= plen;
                    rem              <= plen;
                end
            end
            if (acc && state == S_PAYLOAD) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_axis_tlast || rem == 16'd1;
                rem           <= rem - 16'd1;
                if (s_axis_tlast && rem != 16'd1) meta_truncated <= 1'b1;
            end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
            if (drop_evt && stat_drop_frames != '1) stat_drop_frames <= stat_drop_frames + 1'b1;
            if (meta_valid && meta_ready && stat_rx_frames != '1) stat_rx_frames <= stat_rx_frames + 1'b1;
        end
    end
endmodule

// File: tb/tb_ethernet_ipv4_parser.sv
// tb_ethernet_ipv4_parser: scoreboard bench for ethernet_ipv4_parser
module tb_ethernet_ipv4_parser;
    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic        vp;
        logic [11:0] vid;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [7:0]  proto;
        logic [15:0] plen;
        logic        trunc;
    } meta_t;
    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC   = 48'h02_00_00_00_00_aa;
    localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0, m_axis_tdata;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic        meta_valid, meta_ready = 1'b1;
    logic [47:0] meta_dst_mac, meta_src_mac, cfg_local_mac = LOCAL;
    logic        meta_vlan_present, meta_truncated;
    logic [11:0] meta_vlan_id;
    logic [31:0] meta_src_ip, meta_dst_ip;
    logic [7:0]  meta_protocol;
    logic [15:0] meta_payload_len, stat_rx_frames, stat_drop_frames;
    int          errors = 0, checks = 0, exp_rx = 0, exp_drop = 0, pay_lo = 0, pay_hi = 0;
    bit          tog = 0, chk = 0, in_pay = 0;
    logic [7:0]  frm[$];
    logic [8:0]  exp_q[$];
    meta_t       meta_q[$];
    logic [8:0]  e_beat;
    meta_t       e_meta, a_meta;
    always #5 clk = ~clk;
    ethernet_ipv4_parser dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
        .meta_vlan_present(meta_vlan_present), .meta_vlan_id(meta_vlan_id), .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip),
        .meta_protocol(meta_protocol), .meta_payload_len(meta_payload_len), .meta_truncated(meta_truncated),
        .cfg_local_mac(cfg_local_mac), .stat_rx_frames(stat_rx_frames), .stat_drop_frames(stat_drop_frames)
    );
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected beat last=%b data=%h, required no beat", m_axis_tlast, m_axis_tdata);
            end else begin
                e_beat = exp_q.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== e_beat) begin
                    errors++;
                    $display("FAIL beat: got last/data=%h required %h", {m_axis_tlast, m_axis_tdata}, e_beat);
                end
            end
        end
        if (meta_valid && meta_ready) begin
            checks++;
            a_meta = {meta_dst_mac, meta_src_mac, meta_vlan_present, meta_vlan_id, meta_src_ip, meta_dst_ip,
                      meta_protocol, meta_payload_len, meta_truncated};
            if (meta_q.size() == 0) begin
                errors++;
                $display("FAIL meta: unexpected meta %h, required none", a_meta);
            end else begin
                e_meta = meta_q.pop_front();
                if (a_meta !== e_meta || m_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL meta: got %h (m_tvalid=%b) required %h (m_tvalid=0)", a_meta, m_axis_tvalid, e_meta);
                end
            end
        end
        if (chk && in_pay) begin
            checks++;
            if (s_axis_tready !== (!m_axis_tvalid || m_axis_tready)) begin
                errors++;
                $display("FAIL stall: s_tready=%b required %b", s_axis_tready, !m_axis_tvalid || m_axis_tready);
            end
        end
    end
    task automatic build(input logic [47:0] dst, input bit tag, input logic [11:0] vid, input logic [3:0] ihl,
                         input int plen, input bit corrupt, input bit ok, input int trunc, input logic [7:0] seed);
        logic [7:0]  h[64];
        logic [31:0] sip, dip;
        logic [15:0] tl, cs;
        logic [7:0]  b;
        int          s, hl, n;
        meta_t       m;
        sip = 32'h0a00_0001;
        dip = 32'hc0a8_0102;
        hl  = 4 * int'(ihl);
        tl  = 16'(hl + plen);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(SRC[8*i +: 8]);
        if (tag) begin
            frm.push_back(8'h81); frm.push_back(8'h00);
            frm.push_back({4'h0, vid[11:8]}); frm.push_back(vid[7:0]);
        end
        frm.push_back(8'h08); frm.push_back(8'h00);
        for (int i = 0; i < 64; i++) h[i] = 8'(i);
        h[0] = {4'h4, ihl}; h[1] = 8'h00; h[2] = tl[15:8]; h[3] = tl[7:0];
        for (int i = 4; i < 8; i++) h[i] = 8'h00;
        h[8] = 8'd64; h[9] = 8'd17; h[10] = 8'h00; h[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[12+i] = sip[8*(3-i) +: 8];
            h[16+i] = dip[8*(3-i) +: 8];
        end
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({h[i], h[i+1]});
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        cs = ~16'(s);
        h[10] = cs[15:8];
        h[11] = cs[7:0] ^ (corrupt ? 8'h01 : 8'h00);
        for (int i = 0; i < hl; i++) frm.push_back(h[i]);
        pay_lo = frm.size();
        n = trunc > 0 ? trunc : plen;
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i * 7);
            frm.push_back(b);
            if (ok) exp_q.push_back({i == n - 1, b});
        end
        pay_hi = frm.size();
        if (trunc == 0) begin
            while (frm.size() < 56) frm.push_back(8'h00);
            for (int i = 0; i < 4; i++) frm.push_back(8'hc0 + 8'(i));
        end
        if (ok) begin
            m.dst = dst; m.src = SRC; m.vp = tag; m.vid = tag ? vid : 12'h000;
            m.sip = sip; m.dip = dip; m.proto = 8'd17; m.plen = 16'(plen); m.trunc = trunc > 0;
            meta_q.push_back(m);
            exp_rx++;
        end
    endtask
    task automatic send(input int nmax);
        int  n, lim;
        bit  ok;
        lim = nmax < frm.size() ? nmax : frm.size();
        for (int i = 0; i < lim; i++) begin
            s_axis_tdata  = frm[i];
            s_axis_tlast  = i == frm.size() - 1;
            s_axis_tvalid = 1'b1;
            in_pay        = i >= pay_lo && i < pay_hi;
            n = 0;
            forever begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                if (tog) m_axis_tready = !m_axis_tready;
                if (ok) break;
                if (++n > 200) begin
                    checks++; errors++;
                    $display("FAIL accept: byte %0d not accepted in 200 cycles, required acceptance", i);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        in_pay        = 1'b0;
    endtask
    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || meta_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || meta_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: beats left=%0d meta left=%0d, required 0 and 0", name, exp_q.size(), meta_q.size());
        end
        checks++;
        if ({stat_rx_frames, stat_drop_frames} !== {16'(exp_rx), 16'(exp_drop)}) begin
            errors++;
            $display("FAIL %s stats: rx=%0d drop=%0d required rx=%0d drop=%0d", name, stat_rx_frames, stat_drop_frames, exp_rx, exp_drop);
        end
    endtask
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, meta_valid, stat_rx_frames, stat_drop_frames, meta_dst_mac} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 16'd0, 48'd0}) begin
            errors++;
            $display("FAIL reset: s_tready=%b m_tvalid=%b meta_valid=%b rx=%0d drop=%0d, required 1 0 0 0 0",
                     s_axis_tready, m_axis_tvalid, meta_valid, stat_rx_frames, stat_drop_frames);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic test_basic();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'h10);
        send(1000);
        wait_done("basic");
    endtask
    task automatic test_bad_csum();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 1, 0, 0, 8'h20);
        exp_drop++;
        send(1000);
        wait_done("bad_csum");
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'h30);
        send(1000);
        wait_done("after_bad_csum");
    endtask
    task automatic test_vlan();
        int n = 0;
        meta_ready = 1'b0;
        build(LOCAL, 1, 12'h123, 4'd6, 10, 0, 1, 0, 8'h40);
        send(1000);
        while (!meta_valid && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({meta_valid, s_axis_tready, meta_vlan_id} !== {1'b1, 1'b0, 12'h123}) begin
            errors++;
            $display("FAIL vlan_hold: meta_valid=%b s_tready=%b vid=%h, required 1 0 123", meta_valid, s_axis_tready, meta_vlan_id);
        end
        @(posedge clk);
        #1 meta_ready = 1'b1;
        wait_done("vlan");
    endtask
    task automatic test_backpressure();
        tog = 1; chk = 1;
        build(LOCAL, 0, 12'h0, 4'd5, 16, 0, 1, 0, 8'h55);
        send(1000);
        tog = 0; chk = 0;
        m_axis_tready = 1'b1;
        wait_done("backpressure");
    endtask
    task automatic test_mac_filter();
        build(48'h02_00_00_00_00_09, 0, 12'h0, 4'd5, 8, 0, 0, 0, 8'h60);
        exp_drop++;
        send(1000);
        wait_done("mac_foreign");
        build(BCAST, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'h70);
        send(1000);
        wait_done("mac_bcast");
    endtask
    task automatic test_zero_payload();
        build(LOCAL, 0, 12'h0, 4'd5, 0, 0, 1, 0, 8'h00);
        send(1000);
        wait_done("zero_payload");
    endtask
    task automatic test_runt();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 0, 0, 8'h80);
        while (frm.size() > 10) void'(frm.pop_back());
        exp_drop++;
        send(1000);
        wait_done("runt");
    endtask
    task automatic test_back_to_back();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'h90);
        send(1000);
        build(LOCAL, 1, 12'habc, 4'd5, 12, 0, 1, 0, 8'ha0);
        send(1000);
        wait_done("back_to_back");
    endtask
    task automatic test_truncated();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 3, 8'hb0);
        send(1000);
        wait_done("truncated");
    endtask
    task automatic test_reset_mid();
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'hc0);
        send(pay_lo + 3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, meta_valid, meta_truncated, meta_payload_len,
             meta_dst_mac, stat_rx_frames, stat_drop_frames} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 48'd0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_mid: s_tready=%b m_tvalid=%b m_tlast=%b meta_valid=%b plen=%0d rx=%0d drop=%0d, required 1 0 0 0 0 0 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, meta_valid, meta_payload_len, stat_rx_frames, stat_drop_frames);
        end
        exp_q.delete();
        meta_q.delete();
        exp_rx = 0;
        exp_drop = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        build(LOCAL, 0, 12'h0, 4'd5, 8, 0, 1, 0, 8'hd0);
        send(1000);
        wait_done("after_reset_mid");
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_vlan();
        test_backpressure();
        test_mac_filter();
        test_zero_payload();
        test_runt();
        test_back_to_back();
        test_truncated();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
